// File: rtl/fp16_softmax_pkg.sv
// Shared FP16 types and vector geometry for the softmax datapath.
package fp16_softmax_pkg;

    typedef logic [15:0] fp16_t;

    localparam int N         = 64;
    localparam int OUT_LANES = 4;
    localparam int BEATS     = N / OUT_LANES;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/fp16_vec_serializer.sv
// Ping-pong buffered serializer: accepts whole FP16 vectors and streams them
// out OUT_LANES lanes per beat with zero bubbles between consecutive vectors.
//
// state     | meaning
// OCC_EMPTY | no vector buffered, output idle
// OCC_ONE   | one vector buffered, streaming it, other slot free
// OCC_FULL  | both slots hold vectors, input back-pressured
module fp16_vec_serializer
    import fp16_softmax_pkg::*;
#(
    parameter int N         = fp16_softmax_pkg::N,
    parameter int OUT_LANES = fp16_softmax_pkg::OUT_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N*16-1:0]         vec_in,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    output logic [OUT_LANES*16-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast
);

    localparam int BEATS = N / OUT_LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    occ_t            count;
    occ_t            count_nxt;
    fp16_t [N-1:0]   slot [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            en;
    logic [BW-1:0]   beat;
    logic            accept;
    logic            pop;
    logic            last_pop;

    // en holds vec_ready low until the first edge after reset release
    assign vec_ready = en && (count != OCC_FULL);
    assign m_tvalid  = (count != OCC_EMPTY);
    assign m_tlast   = m_tvalid && (beat == LAST_BEAT);
    assign m_tdata   = slot[rd_ptr][int'(beat)*OUT_LANES +: OUT_LANES];

    assign accept    = vec_valid && vec_ready;
    assign pop       = m_tvalid && m_tready;
    assign last_pop  = pop && (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= OCC_EMPTY;
        end else begin
            count <= count_nxt;
        end
    end

    always_comb begin
        count_nxt = count;
        if (accept && !last_pop) begin
            count_nxt = (count == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        end else if (!accept && last_pop) begin
            count_nxt = (count == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        end
    end

    // A slot is only written when count != FULL, so wr_ptr never aliases a
    // slot that still has beats pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            beat    <= '0;
            en      <= 1'b0;
        end else begin
            en <= 1'b1;
            if (accept) begin
                slot[wr_ptr] <= vec_in;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                beat <= last_pop ? '0 : beat + 1'b1;
                if (last_pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_vec_serializer.sv
// Scoreboard bench: accepted vectors queue their expected beats, a negedge
// monitor pops and compares every beat the DUT hands over.
module tb_fp16_vec_serializer;
    import fp16_softmax_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N*16-1:0]         vec_in = '0;
    logic                    vec_valid = 1'b0;
    logic                    vec_ready;
    logic [OUT_LANES*16-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready = 1'b0;
    logic                    m_tlast;

    fp16_vec_serializer #(.N(N), .OUT_LANES(OUT_LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_in    (vec_in),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    beats_seen = 0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*16-1:0] make_vec(input logic [15:0] base);
        logic [N*16-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = base + 16'(i);
        return v;
    endfunction

    function automatic logic [63:0] beat_data(input logic [15:0] base, input int b);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < OUT_LANES; j++) d[j*16 +: 16] = base + 16'(b*OUT_LANES + j);
        return d;
    endfunction

    task automatic push_vec(input logic [15:0] base);
        beat_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.data = beat_data(base, b);
            e.last = (b == BEATS-1);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // vec_valid must already be high; returns at accept edge + 1
    task automatic wait_accept(input logic [15:0] base, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles && !ok; n++) begin
            @(negedge clk);
            if (vec_ready) begin
                push_vec(base);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        vec_valid = 1'b0;
        check_bit("accept_in_time", ok, 1'b1);
    endtask

    task automatic send_vec(input logic [15:0] base, input int max_cycles);
        vec_in    = make_vec(base);
        vec_valid = 1'b1;
        wait_accept(base, max_cycles);
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            if (exp_q.size() == 0 && !m_tvalid) done = 1'b1;
            else cyc(1);
        end
        check_bit("drain_complete", done, 1'b1);
    endtask

    // monitor: compare popped beats, and hold stability across stalls
    beat_t       mon_e;
    bit          hold = 1'b0;
    logic [63:0] hold_data;
    logic        hold_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_bit("stall_tvalid", m_tvalid, 1'b1);
                check_val("stall_tdata", m_tdata, hold_data);
                check_bit("stall_tlast", m_tlast, hold_last);
            end
            hold = 1'b0;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_bit("unexpected_beat", m_tvalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("beat_data", m_tdata, mon_e.data);
                    check_bit("beat_last", m_tlast, mon_e.last);
                    beats_seen++;
                end
            end else if (m_tvalid) begin
                hold      = 1'b1;
                hold_data = m_tdata;
                hold_last = m_tlast;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;

        // reset state
        #2;
        check_bit("rst_vec_ready", vec_ready, 1'b0);
        check_bit("rst_tvalid", m_tvalid, 1'b0);
        check_bit("rst_tlast", m_tlast, 1'b0);
        check_val("rst_tdata", m_tdata, 64'h0);
        #20 rst_n = 1'b1;
        #1 check_bit("ready_before_first_edge", vec_ready, 1'b0);
        @(posedge clk); #1;
        check_bit("ready_after_first_edge", vec_ready, 1'b1);

        // single vector, m_tready held high
        m_tready = 1'b1;
        b0 = beats_seen;
        send_vec(16'h3C00, 5);
        check_bit("lat_tvalid", m_tvalid, 1'b1);
        check_val("lat_beat0", m_tdata, 64'h3C03_3C02_3C01_3C00);
        check_bit("lat_beat0_last", m_tlast, 1'b0);
        cyc(15);
        check_val("beat15_data", m_tdata, 64'h3C3F_3C3E_3C3D_3C3C);
        check_bit("beat15_last", m_tlast, 1'b1);
        cyc(1);
        check_bit("idle_after_vec", m_tvalid, 1'b0);
        check_int("vec1_beats", beats_seen - b0, 16);

        // two vectors back to back with output stalled, third held off
        m_tready = 1'b0;
        send_vec(16'h4000, 5);
        send_vec(16'h4100, 5);
        check_bit("full_ready", vec_ready, 1'b0);
        vec_in    = make_vec(16'h4200);
        vec_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("third_held", vec_ready, 1'b0);
            @(posedge clk); #1;
        end
        check_val("full_head", m_tdata, 64'h4003_4002_4001_4000);

        // final pop from FULL with a vector waiting
        m_tready = 1'b1;
        cyc(15);
        check_bit("pop_cycle_last", m_tlast, 1'b1);
        check_bit("pop_cycle_ready", vec_ready, 1'b0);
        cyc(1);
        check_bit("after_pop_ready", vec_ready, 1'b1);
        check_val("no_bubble_head", m_tdata, 64'h4103_4102_4101_4100);
        wait_accept(16'h4200, 3);
        check_bit("refill_full", vec_ready, 1'b0);
        drain(200);

        // m_tready toggling 1,0
        b0 = beats_seen;
        send_vec(16'h5000, 5);
        for (int i = 0; i < 32; i++) begin
            if (i == 30) check_bit("toggle_last_at_30", m_tlast, 1'b1);
            m_tready = (i % 2 == 0);
            cyc(1);
        end
        check_bit("toggle_done", m_tvalid, 1'b0);
        check_int("toggle_beats", beats_seen - b0, 16);
        m_tready = 1'b1;

        // new vector accepted on the cycle the last beat pops (count stays ONE)
        send_vec(16'h6000, 5);
        cyc(15);
        check_bit("prepop_last", m_tlast, 1'b1);
        vec_in    = make_vec(16'h6100);
        vec_valid = 1'b1;
        wait_accept(16'h6100, 2);
        check_bit("swap_tvalid", m_tvalid, 1'b1);
        check_val("swap_beat0", m_tdata, 64'h6103_6102_6101_6100);
        check_bit("swap_ready_one", vec_ready, 1'b1);

        // asynchronous reset mid-vector at beat 7
        cyc(7);
        check_val("beat7_data", m_tdata, 64'h611F_611E_611D_611C);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_bit("async_tvalid", m_tvalid, 1'b0);
        check_val("async_tdata", m_tdata, 64'h0);
        check_bit("async_ready", vec_ready, 1'b0);
        check_bit("async_tlast", m_tlast, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_bit("rel_ready_before_edge", vec_ready, 1'b0);
        @(posedge clk); #1;
        check_bit("rel_ready_after_edge", vec_ready, 1'b1);
        check_bit("rel_tvalid", m_tvalid, 1'b0);
        cyc(20);
        check_bit("no_residual", m_tvalid, 1'b0);

        b0 = beats_seen;
        send_vec(16'h7000, 5);
        drain(100);
        check_int("recover_beats", beats_seen - b0, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
